// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the two-port PSRAM APB arbiter.
package psram_arb_pkg;

    localparam int unsigned STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_t;

    localparam logic [STRB_WIDTH-1:0] STB_B = 4'b0001;
    localparam logic [STRB_WIDTH-1:0] STB_H = 4'b0011;
    localparam logic [STRB_WIDTH-1:0] STB_W = 4'b1111;

    // Only byte, halfword and word strobes are understood by the psram.
    function automatic logic strb_legal(input logic [STRB_WIDTH-1:0] strb);
        return (strb == STB_B) || (strb == STB_H) || (strb == STB_W);
    endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester (I/D) and psram APB signals of the arbiter.
// slave : arbiter view (serves requesters, drives the psram port)
// master: environment view (requesters plus the psram itself)
interface psram_arbiter_if
    import psram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_err;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_write;
    logic [STRB_WIDTH-1:0] d_strb;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic [ADDR_WIDTH-1:0] m_paddr;
    logic [DATA_WIDTH-1:0] m_pdata;
    logic                  m_pwrite;
    logic [STRB_WIDTH-1:0] m_pstb;
    logic                  m_psel;
    logic                  m_penable;
    logic [DATA_WIDTH-1:0] m_prdata;
    logic                  m_pready;
    logic                  m_perr;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata, i_err,
        input  d_req, d_addr, d_wdata, d_write, d_strb,
        output d_ack, d_rdata, d_err,
        output m_paddr, m_pdata, m_pwrite, m_pstb, m_psel, m_penable,
        input  m_prdata, m_pready, m_perr
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata, i_err,
        output d_req, d_addr, d_wdata, d_write, d_strb,
        input  d_ack, d_rdata, d_err,
        input  m_paddr, m_pdata, m_pwrite, m_pstb, m_psel, m_penable,
        output m_prdata, m_pready, m_perr
    );

endinterface

// File: rtl/psram_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D).
// PSRAM_ARB_RR_EN: round-robin, tie goes to rr_ptr (0 = I, 1 = D).
// Otherwise fixed priority D over I.
module psram_arb_pick
    import psram_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   rr_ptr,
    output grant_t gnt_c
);

    // Winner for the current IDLE cycle.
    always_comb begin
        gnt_c = NONE;
`ifdef PSRAM_ARB_RR_EN
        if (i_req && d_req) begin
            gnt_c = rr_ptr ? GNT_D : GNT_I;
        end else if (d_req) begin
            gnt_c = GNT_D;
        end else if (i_req) begin
            gnt_c = GNT_I;
        end
`else
        if (d_req) begin
            gnt_c = GNT_D;
        end else if (i_req) begin
            gnt_c = GNT_I;
        end
`endif
    end

`ifndef PSRAM_ARB_RR_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;
`endif

endmodule

// File: rtl/psram_arbiter.sv
// Shares the APB-style psram port between fetch (I, read-only) and
// load/store (D). Runs SETUP/ACCESS and holds psel/penable until pready.
// Optional macro PSRAM_ARB_RR_EN selects round-robin arbitration.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic            pclk,
    input  logic            rst,
    psram_arbiter_if.slave  bus
);

    state_t state_q, state_d;
    grant_t grant_q, grant_d;
    logic   rr_ptr_q, rr_ptr_d;
    grant_t pick_gnt;
    logic   cmd_load;
    logic   xfer_done;
    logic   strb_fault;
    logic   i_req_live;
    logic   d_req_live;

    // A port whose ack is showing is still holding req for this cycle only.
    assign i_req_live = bus.i_req && !bus.i_ack;
    assign d_req_live = bus.d_req && !bus.d_ack;

    psram_arb_pick u_pick (
        .i_req  (i_req_live),
        .d_req  (d_req_live),
        .rr_ptr (rr_ptr_q),
        .gnt_c  (pick_gnt)
    );

    // State, grant and round-robin pointer registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= NONE;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state, grant and transfer events.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cmd_load   = 1'b0;
        xfer_done  = 1'b0;
        strb_fault = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = NONE;
                if (pick_gnt == GNT_D && !strb_legal(bus.d_strb)) begin
                    // Rejected without a bus cycle; still counts as D's turn.
                    strb_fault = 1'b1;
                    rr_ptr_d   = 1'b0;
                end else if (pick_gnt != NONE) begin
                    grant_d  = pick_gnt;
                    cmd_load = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.m_pready) begin
                    xfer_done = 1'b1;
                    state_d   = IDLE;
                    grant_d   = NONE;
                    rr_ptr_d  = (grant_q == GNT_I);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = NONE;
            end
        endcase
    end

    // Registered bus controls, command latch and requester responses.
    always_ff @(posedge pclk) begin
        if (rst) begin
            bus.m_psel    <= 1'b0;
            bus.m_penable <= 1'b0;
            bus.m_paddr   <= '0;
            bus.m_pdata   <= '0;
            bus.m_pwrite  <= 1'b0;
            bus.m_pstb    <= '0;
            bus.i_ack     <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.m_psel    <= (state_d != IDLE);
            bus.m_penable <= (state_d == ACCESS);
            bus.i_ack     <= xfer_done && (grant_q == GNT_I);
            bus.i_err     <= xfer_done && (grant_q == GNT_I) && bus.m_perr;
            bus.d_ack     <= (xfer_done && (grant_q == GNT_D)) || strb_fault;
            bus.d_err     <= (xfer_done && (grant_q == GNT_D) && bus.m_perr) || strb_fault;
            if (xfer_done && grant_q == GNT_I) begin
                bus.i_rdata <= DATA_WIDTH'(bus.m_prdata);
            end
            if (xfer_done && grant_q == GNT_D) begin
                bus.d_rdata <= DATA_WIDTH'(bus.m_prdata);
            end
            if (cmd_load) begin
                if (pick_gnt == GNT_I) begin
                    bus.m_paddr  <= ADDR_WIDTH'(bus.i_addr);
                    bus.m_pdata  <= '0;
                    bus.m_pwrite <= 1'b0;
                    bus.m_pstb   <= STB_W;
                end else begin
                    bus.m_paddr  <= ADDR_WIDTH'(bus.d_addr);
                    bus.m_pdata  <= DATA_WIDTH'(bus.d_wdata);
                    bus.m_pwrite <= bus.d_write;
                    bus.m_pstb   <= bus.d_strb;
                end
            end
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed, table-driven bench for psram_arbiter.
// Each row drives inputs for one cycle; the expected outputs are those
// visible in the following cycle.
module tb_psram_arbiter;
    import psram_arb_pkg::*;

    logic pclk;
    logic rst;

    psram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    psram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_write;
        logic [3:0]  d_strb;
        logic        m_pready;
        logic        m_perr;
        logic [31:0] m_prdata;
    } in_t;

    typedef struct packed {
        logic        psel;
        logic        pen;
        logic [31:0] paddr;
        logic [31:0] pdata;
        logic        pwrite;
        logic [3:0]  pstb;
        logic        i_ack;
        logic        i_err;
        logic        d_ack;
        logic        d_err;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [31:0] W  = 32'hDEAD_BEEF;
    localparam logic [31:0] I1 = 32'h1111_2222;
    localparam logic [31:0] C  = 32'hCAFE_0001;
    localparam logic [31:0] BD = 32'hBAD0_BAD0;
    localparam logic [31:0] A5 = 32'h0000_00A5;

    function automatic in_t iv(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                               logic [31:0] dw, logic dwr, logic [3:0] ds,
                               logic rdy, logic err, logic [31:0] prd);
        in_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_addr = da; v.d_wdata = dw;
        v.d_write = dwr; v.d_strb = ds; v.m_pready = rdy; v.m_perr = err; v.m_prdata = prd;
        return v;
    endfunction

    function automatic exp_t ev(logic ps, logic pe, logic [31:0] pa, logic [31:0] pd,
                                logic pw, logic [3:0] pst, logic ia, logic ie,
                                logic da, logic de, logic [31:0] ir, logic [31:0] dr);
        exp_t v;
        v.psel = ps; v.pen = pe; v.paddr = pa; v.pdata = pd; v.pwrite = pw; v.pstb = pst;
        v.i_ack = ia; v.i_err = ie; v.d_ack = da; v.d_err = de; v.i_rdata = ir; v.d_rdata = dr;
        return v;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        bus.i_req    = v.i_req;
        bus.i_addr   = v.i_addr;
        bus.d_req    = v.d_req;
        bus.d_addr   = v.d_addr;
        bus.d_wdata  = v.d_wdata;
        bus.d_write  = v.d_write;
        bus.d_strb   = v.d_strb;
        bus.m_pready = v.m_pready;
        bus.m_perr   = v.m_perr;
        bus.m_prdata = v.m_prdata;
    endtask

    function automatic exp_t sample();
        return ev(bus.m_psel, bus.m_penable, bus.m_paddr, bus.m_pdata, bus.m_pwrite,
                  bus.m_pstb, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err,
                  bus.i_rdata, bus.d_rdata);
    endfunction

    task automatic check(input string name, input exp_t want);
        exp_t got;
        got = sample();
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic got_ack;
        in_t  z;
        exp_t zero;

        z    = iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle I+D request: D write first (fixed) or I first (RR, ptr=I).
`ifdef PSRAM_ARB_RR_EN
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 0, 'h104, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 1, 'h104, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 1, 0, I1), ev(0, 0, 'h104, 0, 0, 4'hF, 1, 0, 0, 0, I1, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 0, 'h200, W, 1, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(0, 0, 1, 'h200, W, 1, 4'hF, 0, 0, 0),      ev(1, 1, 'h200, W, 1, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(0, 0, 1, 'h200, W, 1, 4'hF, 1, 0, 0),      ev(0, 0, 'h200, W, 1, 4'hF, 0, 0, 1, 0, I1, 0));
        add(iv(0, 0, 1, 'h200, W, 1, 4'hF, 0, 0, 0),      ev(0, 0, 'h200, W, 1, 4'hF, 0, 0, 0, 0, I1, 0));
`else
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 0, 'h200, W, 1, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 1, 'h200, W, 1, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 1, 0, 0),  ev(0, 0, 'h200, W, 1, 4'hF, 0, 0, 1, 0, 0, 0));
        add(iv(1, 'h104, 1, 'h200, W, 1, 4'hF, 0, 0, 0),  ev(1, 0, 'h104, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0),         ev(1, 1, 'h104, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
        add(iv(1, 'h104, 0, 0, 0, 0, 0, 1, 0, I1),        ev(0, 0, 'h104, 0, 0, 4'hF, 1, 0, 0, 0, I1, 0));
        add(iv(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0),         ev(0, 0, 'h104, 0, 0, 4'hF, 0, 0, 0, 0, I1, 0));
`endif
        // Fetch 0x100 with pready on the 3rd ACCESS cycle; ack in cycle 5.
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), ev(1, 0, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), ev(1, 1, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), ev(1, 1, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), ev(1, 1, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, I1, 0));
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 1, 0, C), ev(0, 0, 'h100, 0, 0, 4'hF, 1, 0, 0, 0, C, 0));
        add(iv(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), ev(0, 0, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, C, 0));
        // Illegal strobe: no bus cycle, d_ack+d_err next cycle, d_rdata kept.
        add(iv(0, 0, 1, 'h300, 'h55, 1, 4'b0101, 0, 0, 0), ev(0, 0, 'h100, 0, 0, 4'hF, 0, 0, 1, 1, C, 0));
        add(iv(0, 0, 1, 'h300, 'h55, 1, 4'b0101, 0, 0, 0), ev(0, 0, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, C, 0));
        add(z,                                             ev(0, 0, 'h100, 0, 0, 4'hF, 0, 0, 0, 0, C, 0));
        // D halfword read ends with perr; following byte read is clean.
        add(iv(0, 0, 1, 'h400, 0, 0, 4'b0011, 0, 0, 0),  ev(1, 0, 'h400, 0, 0, 4'b0011, 0, 0, 0, 0, C, 0));
        add(iv(0, 0, 1, 'h400, 0, 0, 4'b0011, 0, 0, 0),  ev(1, 1, 'h400, 0, 0, 4'b0011, 0, 0, 0, 0, C, 0));
        add(iv(0, 0, 1, 'h400, 0, 0, 4'b0011, 1, 1, BD), ev(0, 0, 'h400, 0, 0, 4'b0011, 0, 0, 1, 1, C, BD));
        add(iv(0, 0, 1, 'h400, 0, 0, 4'b0011, 0, 0, 0),  ev(0, 0, 'h400, 0, 0, 4'b0011, 0, 0, 0, 0, C, BD));
        add(iv(0, 0, 1, 'h404, 0, 0, 4'b0001, 0, 0, 0),  ev(1, 0, 'h404, 0, 0, 4'b0001, 0, 0, 0, 0, C, BD));
        add(iv(0, 0, 1, 'h404, 0, 0, 4'b0001, 0, 0, 0),  ev(1, 1, 'h404, 0, 0, 4'b0001, 0, 0, 0, 0, C, BD));
        add(iv(0, 0, 1, 'h404, 0, 0, 4'b0001, 1, 0, A5), ev(0, 0, 'h404, 0, 0, 4'b0001, 0, 0, 1, 0, C, A5));
        add(iv(0, 0, 1, 'h404, 0, 0, 4'b0001, 0, 0, 0),  ev(0, 0, 'h404, 0, 0, 4'b0001, 0, 0, 0, 0, C, A5));
        add(z,                                           ev(0, 0, 'h404, 0, 0, 4'b0001, 0, 0, 0, 0, C, A5));

        // Reset for two cycles, then release.
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("in_reset", zero);
        rst = 1'b0;
        @(negedge pclk);
        check("after_reset", zero);

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            @(negedge pclk);
            check($sformatf("vec%0d", k), vecs[k].e);
        end

        // Reset during the 2nd ACCESS cycle of a fetch.
        drive(iv(1, 'h500, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge pclk);
        check_bit("mid_access_penable", bus.m_penable, 1'b1);
        rst = 1'b1;
        @(negedge pclk);
        check("rst_mid_access", zero);
        rst = 1'b0;
        drive(z);
        repeat (2) begin
            @(negedge pclk);
            check("post_rst_idle", zero);
        end

        // Fresh fetch after reset, psram ready on the first ACCESS cycle.
        drive(iv(1, 'h600, 0, 0, 0, 0, 0, 0, 0, 32'h600D_600D));
        got_ack = 1'b0;
        lat     = 0;
        for (int c = 1; c <= 20 && !got_ack; c++) begin
            @(negedge pclk);
            if (bus.i_ack) begin
                got_ack = 1'b1;
                lat     = c;
            end
            bus.m_pready = bus.m_psel && bus.m_penable;
        end
        if (!got_ack) begin
            n_vec++;
            n_fail++;
            $display("FAIL fresh_fetch_ack: got no ack in 20 cycles want ack");
        end else begin
            check_bit("fresh_fetch_latency3", (lat == 3), 1'b1);
            check("fresh_fetch_done", ev(0, 0, 'h600, 0, 0, 4'hF, 1, 0, 0, 0, 32'h600D_600D, 0));
        end
        drive(z);
        @(negedge pclk);
        check("final_idle", ev(0, 0, 'h600, 0, 0, 4'hF, 0, 0, 0, 0, 32'h600D_600D, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
